// File: rtl/pixel_addr_pkg.sv
// Shared types for the frame-scan address generator: FSM states and scan orders.
package pixel_addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    RASTER     = 1'b0,
    MACROBLOCK = 1'b1
  } scan_mode_e;

endpackage

// File: rtl/addr_ctrl.sv
// Scan sequencer: IDLE/SCAN/DONE control plus the scan mode captured at start.
// Latency: beats start the cycle after start; done pulses the cycle after the last transfer.
module addr_ctrl
  import pixel_addr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       mode_i,
  input  logic       xfer_i,
  input  logic       last_frame_i,
  output scan_mode_e mode_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       launch_o,
  output logic       clear_o
);

  state_e     state_q, state_d;
  scan_mode_e mode_q, mode_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= RASTER;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    launch_o = 1'b0;
    clear_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SCAN;
          mode_d   = scan_mode_e'(mode_i);
          launch_o = 1'b1;
        end
      end
      SCAN: begin
        // Abort wins over a transfer landing on the same edge.
        if (abort_i) begin
          state_d = IDLE;
          clear_o = 1'b1;
        end else if (xfer_i && last_frame_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        clear_o = abort_i;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mode_o  = mode_q;
  assign valid_o = (state_q == SCAN);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

endmodule

// File: rtl/mb_pixel_addr.sv
// Frame pixel coordinate/address generator with raster or macroblock scan order.
// Valid/ready output: coordinates hold while ready is low; addr is combinational from x/y.
module mb_pixel_addr
  import pixel_addr_pkg::*;
#(
  parameter int FRAME_W = 1920,
  parameter int FRAME_H = 1088,
  parameter int MB_W    = 16,
  parameter int MB_H    = 16,
  parameter int COORD_W = 16,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic               ready,
  output logic               valid,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr,
  output logic               last_mb,
  output logic               last_frame,
  output logic               busy,
  output logic               done
);

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(FRAME_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(FRAME_H - 1);
  localparam logic [COORD_W-1:0] MB_W_C   = COORD_W'(MB_W);
  localparam logic [COORD_W-1:0] MB_H_C   = COORD_W'(MB_H);
  localparam logic [COORD_W-1:0] MB_W_M1  = COORD_W'(MB_W - 1);
  localparam logic [COORD_W-1:0] MB_H_M1  = COORD_W'(MB_H - 1);
  localparam logic [COORD_W-1:0] MBX_LAST = COORD_W'(FRAME_W - MB_W);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  // Origin of the macroblock currently being walked (macroblock order only).
  logic [COORD_W-1:0] mbx_q, mbx_d, mby_q, mby_d;

  scan_mode_e scan_mode;
  logic       launch, clear, xfer;
  logic       x_end_mb, y_end_mb, at_frame_end;

  addr_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .abort_i     (abort),
    .mode_i      (mode),
    .xfer_i      (xfer),
    .last_frame_i(last_frame),
    .mode_o      (scan_mode),
    .valid_o     (valid),
    .busy_o      (busy),
    .done_o      (done),
    .launch_o    (launch),
    .clear_o     (clear)
  );

  assign xfer         = valid && ready;
  assign x_end_mb     = (x_q == mbx_q + MB_W_M1);
  assign y_end_mb     = (y_q == mby_q + MB_H_M1);
  assign at_frame_end = (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '0;
      y_q   <= '0;
      mbx_q <= '0;
      mby_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      mbx_q <= mbx_d;
      mby_q <= mby_d;
    end
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    mbx_d = mbx_q;
    mby_d = mby_q;
    if (clear || launch || (xfer && at_frame_end)) begin
      x_d   = '0;
      y_d   = '0;
      mbx_d = '0;
      mby_d = '0;
    end else if (xfer) begin
      if (scan_mode == RASTER) begin
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end else if (!x_end_mb) begin
        x_d = x_q + 1'b1;
      end else if (!y_end_mb) begin
        x_d = mbx_q;
        y_d = y_q + 1'b1;
      end else if (mbx_q != MBX_LAST) begin
        mbx_d = mbx_q + MB_W_C;
        x_d   = mbx_q + MB_W_C;
        y_d   = mby_q;
      end else begin
        mbx_d = '0;
        mby_d = mby_q + MB_H_C;
        x_d   = '0;
        y_d   = mby_q + MB_H_C;
      end
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign addr = ADDR_W'(y_q) * ADDR_W'(FRAME_W) + ADDR_W'(x_q);

  assign last_frame = valid && at_frame_end;
  assign last_mb    = valid && ((scan_mode == RASTER) ? (x_q == X_LAST) : (x_end_mb && y_end_mb));

endmodule

// File: tb/tb_mb_pixel_addr.sv
// Directed bench for mb_pixel_addr on a 32x32 frame with 16x16 macroblocks.
module tb_mb_pixel_addr;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        mode;
  logic        ready;
  logic        valid;
  logic [15:0] x;
  logic [15:0] y;
  logic [31:0] addr;
  logic        last_mb;
  logic        last_frame;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cur      = 0;

  mb_pixel_addr #(
    .FRAME_W(32),
    .FRAME_H(32),
    .MB_W   (16),
    .MB_H   (16),
    .COORD_W(16),
    .ADDR_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .ready     (ready),
    .valid     (valid),
    .x         (x),
    .y         (y),
    .addr      (addr),
    .last_mb   (last_mb),
    .last_frame(last_frame),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_beat(input int target);
    repeat (target - cur) tick();
    cur = target;
  endtask

  task automatic chk_beat(input string tag, input int ex, input int ey, input int eaddr,
                          input logic elmb, input logic elf);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_x"}, 32'(x), 32'(ex));
    chk({tag, "_y"}, 32'(y), 32'(ey));
    chk({tag, "_addr"}, addr, 32'(eaddr));
    chk({tag, "_last_mb"}, 32'(last_mb), 32'(elmb));
    chk({tag, "_last_frame"}, 32'(last_frame), 32'(elf));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_x"}, 32'(x), 32'd0);
    chk({tag, "_y"}, 32'(y), 32'd0);
    chk({tag, "_addr"}, addr, 32'd0);
    chk({tag, "_last_mb"}, 32'(last_mb), 32'd0);
    chk({tag, "_last_frame"}, 32'(last_frame), 32'd0);
  endtask

  task automatic launch(input logic m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    cur   = 1;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 1'b0;
    ready = 1'b1;
    repeat (3) tick();
    chk_quiet("reset");
    rst = 1'b1;
    repeat (2) tick();
    chk_quiet("post_reset_idle");

    // Macroblock order, with start/mode disturbances mid-scan.
    launch(1'b1);
    chk_beat("mb_b1", 0, 0, 0, 1'b0, 1'b0);
    chk("mb_busy", 32'(busy), 32'd1);
    goto_beat(16);
    chk_beat("mb_b16", 15, 0, 15, 1'b0, 1'b0);
    goto_beat(17);
    chk_beat("mb_b17", 0, 1, 32, 1'b0, 1'b0);
    goto_beat(256);
    chk_beat("mb_b256", 15, 15, 495, 1'b1, 1'b0);
    goto_beat(257);
    chk_beat("mb_b257", 16, 0, 16, 1'b0, 1'b0);
    goto_beat(300);
    start = 1'b1;
    mode  = 1'b0;
    tick();
    start = 1'b0;
    cur   = 301;
    goto_beat(513);
    chk_beat("mb_b513", 0, 16, 512, 1'b0, 1'b0);
    goto_beat(1024);
    chk_beat("mb_b1024", 31, 31, 1023, 1'b1, 1'b1);
    tick();
    chk("mb_done_pulse", 32'(done), 32'd1);
    chk("mb_done_valid", 32'(valid), 32'd0);
    tick();
    chk_quiet("mb_after_done");

    // Raster order.
    launch(1'b0);
    chk_beat("ras_b1", 0, 0, 0, 1'b0, 1'b0);
    goto_beat(32);
    chk_beat("ras_b32", 31, 0, 31, 1'b1, 1'b0);
    goto_beat(33);
    chk_beat("ras_b33", 0, 1, 32, 1'b0, 1'b0);
    goto_beat(1024);
    chk_beat("ras_b1024", 31, 31, 1023, 1'b1, 1'b1);
    tick();
    chk("ras_done_pulse", 32'(done), 32'd1);
    tick();
    chk("ras_done_once", 32'(done), 32'd0);
    chk("ras_idle_busy", 32'(busy), 32'd0);

    // Backpressure, then abort.
    launch(1'b0);
    goto_beat(10);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_beat($sformatf("stall%0d", i), 9, 0, 9, 1'b0, 1'b0);
      tick();
    end
    ready = 1'b1;
    tick();
    cur = 11;
    chk_beat("after_stall_b11", 10, 0, 10, 1'b0, 1'b0);
    goto_beat(100);
    chk_beat("abort_b100", 3, 3, 99, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("abort_next");
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    launch(1'b1);
    chk_beat("restart_b1", 0, 0, 0, 1'b0, 1'b0);
    tick();
    cur = 2;
    chk_beat("restart_b2", 1, 0, 1, 1'b0, 1'b0);

    // Asynchronous reset between edges mid-scan.
    goto_beat(50);
    chk_beat("pre_rst_b50", 1, 3, 97, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_quiet("async_rst");
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk_quiet("rst_release_idle");
    launch(1'b0);
    chk_beat("post_rst_b1", 0, 0, 0, 1'b0, 1'b0);
    goto_beat(32);
    chk_beat("post_rst_b32", 31, 0, 31, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mb_pixel_addr.md
MB_PIXEL_ADDR -- requirements
Module: mb_pixel_addr

Interface
REQ-001 SHALL have parameter FRAME_W, default 1920, frame width in pixels (multiple of MB_W).
REQ-002 SHALL have parameter FRAME_H, default 1088, frame height in pixels (multiple of MB_H).
REQ-003 SHALL have parameter MB_W, default 16, macroblock width in pixels.
REQ-004 SHALL have parameter MB_H, default 16, macroblock height in pixels.
REQ-005 SHALL have parameter COORD_W, default 16, coordinate width in bits.
REQ-006 SHALL have parameter ADDR_W, default 32, linear address width in bits.
REQ-007 clk  input  1  system clock; all state changes on rising edge.
REQ-008 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-009 start  input  1  begin a frame scan; sampled only in IDLE.
REQ-010 abort  input  1  terminate the current scan.
REQ-011 mode  input  1  scan order: 0 = raster, 1 = macroblock; sampled with start.
REQ-012 ready  input  1  consumer accepts the current coordinate.
REQ-013 valid  output  1  x/y/addr hold a coordinate to be consumed.
REQ-014 x  output  COORD_W  pixel column.
REQ-015 y  output  COORD_W  pixel row.
REQ-016 addr  output  ADDR_W  linear address y*FRAME_W + x, modulo 2^ADDR_W.
REQ-017 last_mb  output  1  current beat is the last pixel of a macroblock (mode 1) or of a row (mode 0).
REQ-018 last_frame  output  1  current beat is the last pixel of the frame.
REQ-019 busy  output  1  state is not IDLE.
REQ-020 done  output  1  single-cycle pulse after the last beat is accepted.

Function
REQ-021 SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-022 IDLE->SCAN on start=1; first valid beat (0,0) appears in the next cycle.
REQ-023 In SCAN, valid=1; a beat is transferred only when valid && ready; x/y/addr SHALL remain stable while ready=0.
REQ-024 Mode 0: x increments; at x=FRAME_W-1, x wraps to 0 and y increments.
REQ-025 Mode 1: x increments within the macroblock; at a macroblock column boundary, x returns to the macroblock origin and y increments; at the macroblock end, scanning moves to the next macroblock right (same MB row origin y); after the last macroblock in a row, scanning moves to x=0, y=next MB row origin.
REQ-026 A transfer with last_frame=1 SHALL move SCAN->DONE; DONE SHALL assert done for exactly one cycle, with valid=0, then move to IDLE.
REQ-027 abort=1 in SCAN or DONE SHALL move to IDLE at the next edge; it SHALL NOT raise done and SHALL clear x/y to 0; abort has priority over a simultaneous transfer.
REQ-028 start in SCAN or DONE SHALL be ignored; mode changes after start SHALL NOT affect the scan in progress.
REQ-029 last_mb and last_frame SHALL be combinational from registered x/y and are valid only when valid=1.
REQ-030 addr SHALL be derived from registered x/y with no added latency.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, x=y=0, addr=0, valid=busy=done=last_mb=last_frame=0, latched mode=0, including mid-scan.
REQ-032 After rst deassertion, no beat SHALL be produced until a fresh start.

Structure
REQ-033 The package pixel_addr_pkg SHALL hold the state enum (IDLE, SCAN, DONE) and the scan-mode enum (RASTER, MACROBLOCK).
REQ-034 The FSM SHALL be one sub-module, addr_ctrl; the counters and address arithmetic SHALL reside in mb_pixel_addr.

Verification (FRAME_W=32, FRAME_H=32, MB 16x16)
REQ-035 mode=1, ready=1, start pulse -> beat1 (0,0), beat16 (15,0), beat17 (0,1), beat257 (16,0), beat513 (0,16), beat1024 (31,31) with last_frame=1; done pulse in the next cycle.
REQ-036 mode=0, ready=1 -> beat32 (31,0) with last_mb=1, beat33 (0,1) addr=32, beat1024 (31,31) addr=1023.
REQ-037 ready=0 for 5 cycles while showing beat10 -> x=9,y=0,addr=9 held for all 5 cycles; beat11 (10,0) follows once ready=1.
REQ-038 abort at beat100 -> next cycle IDLE, valid=0, x=y=0, no done; a new start begins at (0,0).
REQ-039 rst low asynchronously mid-scan (between edges) -> all outputs 0 before the next edge; start pulses during SCAN have no effect on the beat sequence.
